// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller for the 5-stage MIPS pipeline.
// Turns lw/sw from the EX/MEM register into valid/ready data-memory bus
// transactions, stalls upstream stages while one is outstanding, and
// registers the results into the MEM/WB boundary.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegwriteM,
    input  logic        MemtoregM,
    input  logic        MemwriteM,
    input  logic [31:0] ALUoutM,
    input  logic [31:0] WritedataM,
    input  logic [4:0]  WriteregM,
    output logic        StallM,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    output logic        RegwriteW,
    output logic        MemtoregW,
    output logic [31:0] ReaddataW,
    output logic [31:0] ALUoutW,
    output logic [4:0]  WriteregW,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Last counter value before the read is abandoned (counter starts at 0).
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        req_valid_q, req_valid_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        regwrite_w_q, regwrite_w_d;
    logic        memtoreg_w_q, memtoreg_w_d;
    logic [31:0] readdata_w_q, readdata_w_d;
    logic [31:0] aluout_w_q, aluout_w_d;
    logic [4:0]  writereg_w_q, writereg_w_d;
    logic        err_q, err_d;
    logic        access_s;
    logic        stall_s;

    assign access_s = MemtoregM | MemwriteM;
    assign stall_s  = (state_q == ST_REQ) || (state_q == ST_WAIT) ||
                      ((state_q == ST_IDLE) && access_s);

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        req_valid_d  = req_valid_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        regwrite_w_d = regwrite_w_q;
        memtoreg_w_d = memtoreg_w_q;
        readdata_w_d = readdata_w_q;
        aluout_w_d   = aluout_w_q;
        writereg_w_d = writereg_w_q;
        err_d        = err_q;
        case (state_q)
            ST_IDLE: begin
                if (access_s) begin
                    // Issue: a store wins over a load when both flags are set.
                    req_valid_d  = 1'b1;
                    we_d         = MemwriteM;
                    addr_d       = {ALUoutM[31:2], 2'b00};
                    wdata_d      = WritedataM;
                    rdata_d      = 32'd0;
                    regwrite_w_d = 1'b0;
                    state_d      = ST_REQ;
                end else begin
                    regwrite_w_d = RegwriteM;
                    memtoreg_w_d = MemtoregM;
                    readdata_w_d = 32'd0;
                    aluout_w_d   = ALUoutM;
                    writereg_w_d = WriteregM;
                end
            end
            ST_REQ: begin
                regwrite_w_d = 1'b0;
                if (mem_req_ready) begin
                    req_valid_d = 1'b0;
                    cnt_d       = 8'd0;
                    if (we_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    req_valid_d = 1'b1;
                end
            end
            ST_WAIT: begin
                regwrite_w_d = 1'b0;
                if (mem_rsp_valid) begin
                    // A response on the timeout edge still delivers real data.
                    rdata_d = mem_rdata;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                // EX/MEM still holds the memory instruction during this cycle.
                regwrite_w_d = RegwriteM;
                memtoreg_w_d = MemtoregM;
                readdata_w_d = rdata_q;
                aluout_w_d   = ALUoutM;
                writereg_w_d = WriteregM;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            rdata_q      <= 32'd0;
            req_valid_q  <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            regwrite_w_q <= 1'b0;
            memtoreg_w_q <= 1'b0;
            readdata_w_q <= 32'd0;
            aluout_w_q   <= 32'd0;
            writereg_w_q <= 5'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            req_valid_q  <= req_valid_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            regwrite_w_q <= regwrite_w_d;
            memtoreg_w_q <= memtoreg_w_d;
            readdata_w_q <= readdata_w_d;
            aluout_w_q   <= aluout_w_d;
            writereg_w_q <= writereg_w_d;
            err_q        <= err_d;
        end
    end

    assign StallM        = stall_s;
    assign mem_req_valid = req_valid_q;
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign RegwriteW     = regwrite_w_q;
    assign MemtoregW     = memtoreg_w_q;
    assign ReaddataW     = readdata_w_q;
    assign ALUoutW       = aluout_w_q;
    assign WriteregW     = writereg_w_q;
    assign mem_err       = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: each instruction is described at
// transaction level (bus ready delay, response delay) and the expected
// cycle-by-cycle stall/bus behaviour and final MEM/WB values are derived from it.
module tb_mem_stage_ctrl;

    localparam int          TO       = 16;
    localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegwriteM, MemtoregM, MemwriteM;
    logic [31:0] ALUoutM, WritedataM;
    logic [4:0]  WriteregM;
    logic        StallM;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        RegwriteW, MemtoregW;
    logic [31:0] ReaddataW, ALUoutW;
    logic [4:0]  WriteregW;
    logic        mem_err;

    int n_checks = 0;
    int n_errors = 0;
    logic model_err = 1'b0;

    mem_stage_ctrl dut (
        .clk(clk), .rst(rst),
        .RegwriteM(RegwriteM), .MemtoregM(MemtoregM), .MemwriteM(MemwriteM),
        .ALUoutM(ALUoutM), .WritedataM(WritedataM), .WriteregM(WriteregM),
        .StallM(StallM),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .RegwriteW(RegwriteW), .MemtoregW(MemtoregW), .ReaddataW(ReaddataW),
        .ALUoutW(ALUoutW), .WriteregW(WriteregW), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One instruction in EX/MEM, held until the stage lets it go.
    // rdly: REQ cycles with ready low before the accepting cycle.
    // rsp_dly: WAIT cycles without a response before it arrives (>= TO means never).
    task automatic run_op(input logic rw, input logic mtr, input logic mw,
                          input logic [31:0] alu, input logic [31:0] wd,
                          input logic [4:0] wr, input int rdly, input int rsp_dly,
                          input logic [31:0] rdata);
        logic access, is_rd, tmo, in_req, in_wait, exp_stall, rsp_now;
        int   ws, n;
        logic [31:0] exp_rd;
        access = mtr | mw;
        is_rd  = mtr & ~mw;
        tmo    = is_rd && (rsp_dly >= TO);
        ws     = !is_rd ? 0 : (tmo ? TO : rsp_dly + 1);
        n      = access ? rdly + 3 + ws : 1;
        RegwriteM  = rw;
        MemtoregM  = mtr;
        MemwriteM  = mw;
        ALUoutM    = alu;
        WritedataM = wd;
        WriteregM  = wr;
        for (int c = 0; c < n; c++) begin
            in_req    = access && (c >= 1) && (c <= rdly + 1);
            in_wait   = is_rd && (c >= rdly + 2) && (c < rdly + 2 + ws);
            exp_stall = access && (c < n - 1);
            rsp_now   = in_wait && (c == rdly + 2 + rsp_dly);
            mem_req_ready = in_req ? (c == rdly + 1) : 1'($urandom_range(0, 1));
            mem_rsp_valid = in_wait ? rsp_now : 1'($urandom_range(0, 1));
            mem_rdata     = rsp_now ? rdata : $urandom;
            @(negedge clk);
            check_val("stall", 32'(StallM), 32'(exp_stall));
            check_val("req_valid", 32'(mem_req_valid), 32'(in_req));
            if (in_req) begin
                check_val("req_addr", mem_addr, {alu[31:2], 2'b00});
                check_val("req_we", 32'(mem_we), 32'(mw));
                check_val("req_wdata", mem_wdata, wd);
            end
            @(posedge clk);
            #1;
            if (exp_stall) begin
                check_val("bubble_regwrite", 32'(RegwriteW), 32'd0);
            end
        end
        if (tmo) begin
            model_err = 1'b1;
        end
        exp_rd = !is_rd ? 32'd0 : (tmo ? ERR_WORD : rdata);
        check_val("w_regwrite", 32'(RegwriteW), 32'(rw));
        check_val("w_memtoreg", 32'(MemtoregW), 32'(mtr));
        check_val("w_aluout", ALUoutW, alu);
        check_val("w_writereg", 32'(WriteregW), 32'(wr));
        check_val("w_readdata", ReaddataW, exp_rd);
        check_val("mem_err", 32'(mem_err), 32'(model_err));
    endtask

    // Start a load and hit reset partway through it.
    task automatic reset_mid_op(input int rdly, input int cycles_in);
        RegwriteM  = 1'b1;
        MemtoregM  = 1'b1;
        MemwriteM  = 1'b0;
        ALUoutM    = $urandom;
        WritedataM = $urandom;
        WriteregM  = 5'($urandom_range(1, 31));
        for (int c = 0; c < cycles_in; c++) begin
            mem_req_ready = (c == rdly + 1);
            mem_rsp_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        check_val("pre_rst_valid", 32'(mem_req_valid),
                  32'((cycles_in >= 1) && (cycles_in <= rdly + 1)));
        #1;
        rst = 1'b1;
        #1;
        check_val("rst_valid", 32'(mem_req_valid), 32'd0);
        check_val("rst_we", 32'(mem_we), 32'd0);
        check_val("rst_addr", mem_addr, 32'd0);
        check_val("rst_regwrite", 32'(RegwriteW), 32'd0);
        check_val("rst_memtoreg", 32'(MemtoregW), 32'd0);
        check_val("rst_readdata", ReaddataW, 32'd0);
        check_val("rst_aluout", ALUoutW, 32'd0);
        check_val("rst_writereg", 32'(WriteregW), 32'd0);
        check_val("rst_err", 32'(mem_err), 32'd0);
        model_err = 1'b0;
        RegwriteM = 1'b0;
        MemtoregM = 1'b0;
        #1;
        check_val("rst_stall", 32'(StallM), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        RegwriteM     = 1'b0;
        MemtoregM     = 1'b0;
        MemwriteM     = 1'b0;
        ALUoutM       = 32'd0;
        WritedataM    = 32'd0;
        WriteregM     = 5'd0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'd0;
        #3;
        check_val("init_valid", 32'(mem_req_valid), 32'd0);
        check_val("init_stall", 32'(StallM), 32'd0);
        check_val("init_regwrite", 32'(RegwriteW), 32'd0);
        check_val("init_readdata", ReaddataW, 32'd0);
        check_val("init_err", 32'(mem_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ALU op, zero-wait load, backpressured store
        run_op(1'b1, 1'b0, 1'b0, 32'h0000_0042, 32'h5555_AAAA, 5'd8, 0, 0, 32'd0);
        run_op(1'b1, 1'b1, 1'b0, 32'h0000_1007, 32'd0, 5'd9, 0, 0, 32'hCAFE_0001);
        run_op(1'b0, 1'b0, 1'b1, 32'h0000_2000, 32'h1234_5678, 5'd3, 4, 0, 32'd0);
        // Timeout, then an ALU op completes normally with mem_err still set
        run_op(1'b1, 1'b1, 1'b0, 32'h0000_3001, 32'd0, 5'd4, 1, 100, 32'h1111_2222);
        run_op(1'b1, 1'b0, 1'b0, 32'h0000_0077, 32'd0, 5'd5, 0, 0, 32'd0);
        // Response on the timeout edge wins; one cycle later it is too late
        run_op(1'b1, 1'b1, 1'b0, 32'h0000_4000, 32'd0, 5'd6, 0, TO - 1, 32'hABCD_0001);
        run_op(1'b1, 1'b1, 1'b0, 32'h0000_4004, 32'd0, 5'd7, 2, TO, 32'hABCD_0002);
        // Both flags: write only, no WAIT, ReaddataW 0
        run_op(1'b1, 1'b1, 1'b1, 32'h0000_5002, 32'h0BAD_F00D, 5'd10, 2, 0, 32'h9999_9999);

        // Reset during REQ (valid must drop at once) and mid-WAIT after a timeout
        reset_mid_op(5, 2);
        run_op(1'b1, 1'b1, 1'b0, 32'h0000_6000, 32'd0, 5'd11, 0, 100, 32'd0);
        reset_mid_op(0, 4);
        run_op(1'b1, 1'b0, 1'b0, 32'h0000_0099, 32'd0, 5'd12, 0, 0, 32'd0);

        // Randomized instruction mix
        for (int i = 0; i < 80; i++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            run_op(1'($urandom_range(0, 1)), (kind == 1) || (kind == 3),
                   (kind == 2) || (kind == 3), $urandom, $urandom,
                   5'($urandom_range(0, 31)), int'($urandom_range(0, 5)),
                   int'($urandom_range(0, 20)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage controller of the 5-stage MIPS pipeline; sits directly downstream of the EX/MEM register and consumes its M-side outputs.
- Turns lw/sw into transactions on a valid/ready data-memory bus, stalling upstream stages while a transaction is outstanding.
- Registers results into the MEM/WB boundary (W-side outputs).

Parameters:
TIMEOUT, 16, max cycles in WAIT before the read is aborted; legal range 1..255.
ERR_DATA, 32'hDEADBEEF, value returned on ReaddataW when a read times out.

Ports:
clk  in  1  clock; all flops on rising edge
rst  in  1  asynchronous, active-high reset
RegwriteM  in  1  register-write enable from EX/MEM
MemtoregM  in  1  load (read) request from EX/MEM
MemwriteM  in  1  store (write) request from EX/MEM
ALUoutM  in  32  byte address / ALU result
WritedataM  in  32  store data
WriteregM  in  5  destination register
StallM  out  1  combinational; 1 = hold PC, IF/ID, ID/EX, EX/MEM
mem_req_valid  out  1  bus request valid (registered)
mem_req_ready  in  1  bus accepts request
mem_we  out  1  1 = write
mem_addr  out  32  word address {addr[31:2],2'b00}
mem_wdata  out  32  write data
mem_rsp_valid  in  1  read data valid
mem_rdata  in  32  read data
RegwriteW  out  1  to MEM/WB consumers
MemtoregW  out  1
ReaddataW  out  32
ALUoutW  out  32
WriteregW  out  5
mem_err  out  1  sticky timeout flag

Behaviour:
- Reset (async, immediate): state=IDLE; every output register 0 (mem_req_valid, mem_we, mem_addr, mem_wdata, all W outputs, mem_err); timeout counter 0. An in-flight transaction is abandoned; mem_req_valid drops without waiting for a clock.
- States: IDLE, REQ, WAIT, DONE.
- access = MemtoregM | MemwriteM.
- Write precedence: if both MemtoregM and MemwriteM are 1, perform a write only; ReaddataW = 0.
- IDLE, access=0:
  - StallM=0.
  - Next edge: W outputs load RegwriteM, MemtoregM, ALUoutM, WriteregM; ReaddataW=0.
  - Latency 1 cycle.
- IDLE, access=1:
  - StallM=1 in the same cycle.
  - Next edge: capture addr, wdata and we=MemwriteM; mem_req_valid<=1; go to REQ; RegwriteW<=0 (bubble).
- REQ:
  - mem_req_valid, mem_addr, mem_wdata and mem_we are held stable until mem_req_ready=1.
  - On the ready edge: mem_req_valid<=0; write -> DONE; read -> WAIT (counter cleared).
- WAIT:
  - mem_rsp_valid=1: capture mem_rdata, go to DONE.
  - Otherwise the counter increments each cycle.
  - Counter reaching TIMEOUT without a response: capture ERR_DATA, set mem_err, go to DONE.
  - A response arriving on the same edge the timeout fires wins: real data is captured and mem_err is not set.
- DONE:
  - StallM=0.
  - Next edge: W outputs load the still-held M inputs plus the captured read data (0 for writes); return to IDLE.
  - The new instruction entering EX/MEM on that edge is evaluated in IDLE the following cycle, so there is no double issue.
- StallM=1 in REQ and WAIT, and in IDLE when access=1; 0 otherwise.
- Every clock edge with StallM=1 writes RegwriteW=0. The other W fields hold their previous values.
- Bus rules:
  - mem_rsp_valid outside WAIT is ignored.
  - mem_req_ready outside REQ is ignored.
- ALUoutM[1:0] is ignored for bus addressing but passed unmodified to ALUoutW.
- mem_err is cleared only by rst.
- Minimum memory op: 3 cycles (IDLE, REQ, DONE) with ready asserted on the first REQ cycle. Reads add 1+ cycles in WAIT.

Test Plan:
- Reset: assert rst mid-WAIT (ready given, no rsp) -> mem_req_valid, StallM-related state and all W outputs = 0 immediately; state IDLE after release.
- ALU op: RegwriteM=1, ALUoutM=32'h0000_0042, WriteregM=5'd8 -> StallM=0; next edge RegwriteW=1, ALUoutW=32'h42, WriteregW=8, ReaddataW=0.
- Load, zero-wait bus: MemtoregM=1, ALUoutM=32'h0000_1007, ready=1, rsp_valid=1 with rdata=32'hCAFE_0001 one cycle after accept -> mem_addr=32'h1004, mem_we=0; StallM high for 3 cycles; then ReaddataW=32'hCAFE_0001, ALUoutW=32'h1007, RegwriteW=1.
- Store, backpressure: MemwriteM=1, ALUoutM=32'h2000, WritedataM=32'h1234_5678, ready low 4 cycles -> valid/addr/wdata/we stable for all 5 REQ cycles; RegwriteW=0 each stalled edge; DONE follows the ready cycle.
- Timeout: load with rsp_valid never asserted, TIMEOUT=16 -> after 16 WAIT cycles ReaddataW=32'hDEADBEEF, mem_err=1 and stays set; a following ALU op completes normally.
- Both flags set: MemtoregM=1, MemwriteM=1 -> mem_we=1, no WAIT state, ReaddataW=0; stray mem_rsp_valid pulses in IDLE/REQ have no effect.
